program_counter: RTL and testbench



---
 rtl/pc_pkg.sv | 26 ++
 rtl/program_counter.sv | 90 +++++++++
 tb/tb_program_counter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : pc_pkg                                                       |
// | Description : Shared defaults, address type and next-PC select encoding    |
// |               for the fetch-stage program counter.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package pc_pkg;

  localparam int unsigned PC_WIDTH = 32;

  typedef logic [PC_WIDTH-1:0] pc_addr_t;

  localparam pc_addr_t PC_RESET_VECTOR = '0;
  localparam pc_addr_t PC_STRIDE       = pc_addr_t'(1);

  // Which source feeds the PC register this cycle; ordered by priority.
  typedef enum logic [1:0] {
    PC_SEL_RESET = 2'd0,
    PC_SEL_JUMP  = 2'd1,
    PC_SEL_INC   = 2'd2,
    PC_SEL_HOLD  = 2'd3
  } pc_sel_e;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/program_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : program_counter                                              |
// | Description : Registered fetch-stage program counter. Each rising edge it  |
// |               resets, loads a jump target, advances by STRIDE, or holds,   |
// |               in that priority order.                                      |
// | Ports       : clk_i             clock, rising edge                         |
// |               rst_i             synchronous active-high reset              |
// |               enable_i          advance PC by STRIDE                       |
// |               jump_i            load jump_address_i                        |
// |               jump_address_i    jump target (WIDTH bits)                   |
// |               pc_current_o      registered current PC                      |
// |               pc_next_o         value PC takes at the next edge            |
// |               jump_misaligned_o advisory misaligned-jump flag              |
// |                                 (only with PC_ALIGN_CHECK_EN defined)      |
// | Options     : `define PC_ALIGN_CHECK_EN to add the misalignment flag.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module program_counter
  import pc_pkg::*;
#(
  parameter int unsigned        WIDTH        = PC_WIDTH,
  parameter logic [WIDTH-1:0]   RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
  parameter logic [WIDTH-1:0]   STRIDE       = WIDTH'(PC_STRIDE)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             jump_i,
  input  logic [WIDTH-1:0] jump_address_i,
`ifdef PC_ALIGN_CHECK_EN
  output logic             jump_misaligned_o,
`endif
  output logic [WIDTH-1:0] pc_current_o,
  output logic [WIDTH-1:0] pc_next_o
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  pc_sel_e          sel;

  // Source select, kept as a named signal so the chosen path is visible
  // in waveforms during debug.
  always_comb begin
    sel = PC_SEL_HOLD;
    if (rst_i) begin
      sel = PC_SEL_RESET;
    end else if (jump_i) begin
      sel = PC_SEL_JUMP;
    end else if (enable_i) begin
      sel = PC_SEL_INC;
    end
  end

  // Increment wraps modulo 2^WIDTH; the carry is intentionally dropped.
  always_comb begin
    pc_d = pc_q;
    case (sel)
      PC_SEL_RESET: pc_d = RESET_VECTOR;
      PC_SEL_JUMP:  pc_d = jump_address_i;
      PC_SEL_INC:   pc_d = pc_q + STRIDE;
      PC_SEL_HOLD:  pc_d = pc_q;
      default:      pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    pc_q <= pc_d;
  end

  assign pc_current_o = pc_q;
  assign pc_next_o    = pc_d;

`ifdef PC_ALIGN_CHECK_EN
  // Advisory only: the jump is still taken unchanged; trap logic decides.
  // With STRIDE == 1 the remainder is always zero, so the flag stays low.
  logic [WIDTH-1:0] jump_rem;

  assign jump_rem          = jump_address_i % STRIDE;
  assign jump_misaligned_o = jump_i & (jump_rem != '0);

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    assert (STRIDE != '0);
  end
`endif
`endif

endmodule : program_counter
`default_nettype wire

// File: tb/tb_program_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_program_counter                                           |
// | Description : Directed self-checking bench for program_counter with        |
// |               default parameters (WIDTH 32, reset vector 0, stride 1).     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_program_counter;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        jump;
  logic [31:0] jump_address;
  logic [31:0] pc_current;
  logic [31:0] pc_next;
`ifdef PC_ALIGN_CHECK_EN
  logic        jump_misaligned;
`endif

  int checks = 0;
  int errors = 0;

  program_counter dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .enable_i          (enable),
    .jump_i            (jump),
    .jump_address_i    (jump_address),
`ifdef PC_ALIGN_CHECK_EN
    .jump_misaligned_o (jump_misaligned),
`endif
    .pc_current_o      (pc_current),
    .pc_next_o         (pc_next)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle away from it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    enable       = 1'b0;
    jump         = 1'b0;
    jump_address = '0;

    // Reset held two edges.
    tick();
    tick();
    check("reset_pc", pc_current, 32'h0000_0000);
    check("reset_next", pc_next, 32'h0000_0000);

    // Release and idle: PC stays at the reset vector.
    rst = 1'b0;
    tick();
    check("post_release", pc_current, 32'h0000_0000);
    for (int i = 0; i < 3; i++) tick();
    check("idle_pc", pc_current, 32'h0000_0000);
    check("idle_next", pc_next, 32'h0000_0000);

    // Three enabled edges.
    enable = 1'b1;
    #1;
    check("inc_next0", pc_next, 32'h0000_0001);
    tick();
    check("inc_1", pc_current, 32'h0000_0001);
    tick();
    check("inc_2", pc_current, 32'h0000_0002);
    tick();
    check("inc_3", pc_current, 32'h0000_0003);
    check("inc_next4", pc_next, 32'h0000_0004);

    // Drop enable: hold.
    enable = 1'b0;
    #1;
    check("hold_next", pc_next, 32'h0000_0003);
    tick();
    tick();
    check("hold_pc", pc_current, 32'h0000_0003);

    // Single-edge jump, then five increments.
    jump_address = 32'hABCD_1234;
    jump         = 1'b1;
    #1;
    check("jump_next", pc_next, 32'hABCD_1234);
`ifdef PC_ALIGN_CHECK_EN
    check("misaligned_stride1", {31'd0, jump_misaligned}, 32'h0);
`endif
    tick();
    check("jump_pc", pc_current, 32'hABCD_1234);
    jump   = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("jump_plus5", pc_current, 32'hABCD_1239);

    // Jump and enable together: load only, no stride.
    jump_address = 32'h0000_FFFF;
    jump         = 1'b1;
    enable       = 1'b1;
    tick();
    check("jump_over_inc", pc_current, 32'h0000_FFFF);

    // Wrap from all-ones.
    jump_address = 32'hFFFF_FFFF;
    enable       = 1'b0;
    tick();
    check("jump_allones", pc_current, 32'hFFFF_FFFF);
    jump   = 1'b0;
    enable = 1'b1;
    #1;
    check("wrap_next", pc_next, 32'h0000_0000);
    tick();
    check("wrap_pc", pc_current, 32'h0000_0000);

    // Reset overrides jump and enable mid-operation.
    jump_address = 32'h0000_1234;
    jump         = 1'b1;
    enable       = 1'b0;
    tick();
    check("jump_1234", pc_current, 32'h0000_1234);
    jump_address = 32'h0000_5555;
    enable       = 1'b1;
    rst          = 1'b1;
    #1;
    check("rst_next", pc_next, 32'h0000_0000);
    check("rst_pc_before_edge", pc_current, 32'h0000_1234);
    tick();
    check("rst_override", pc_current, 32'h0000_0000);

    // After release, enable alone advances from the reset vector.
    rst  = 1'b0;
    jump = 1'b0;
    tick();
    check("after_rst_inc", pc_current, 32'h0000_0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_program_counter
`default_nettype wire
